// File: rtl/warp_barrier_unit.sv
// Core-local warp barrier table with a single-entry release buffer toward the warp scheduler.
// Define BARRIER_PERF_EN to add the stall-cycle and release performance counters.
module warp_barrier_unit #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_BARRIERS  = 4,
    parameter int NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_BITS       = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bar_valid,
    output logic                     bar_ready,
    input  logic [NW_BITS-1:0]       bar_wid,
    input  logic [NB_BITS-1:0]       bar_id,
    input  logic [NW_BITS-1:0]       bar_size_m1,
    output logic                     release_valid,
    input  logic                     release_ready,
    output logic [NB_BITS-1:0]       release_id,
    output logic [NUM_WARPS-1:0]     release_mask,
    output logic [NUM_WARPS-1:0]     stalled_mask,
    output logic                     err_dup,
    output logic                     err_size
`ifdef BARRIER_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_stall_cycles,
    output logic [PERF_CTR_BITS-1:0] perf_releases
`endif
);

    logic                 ent_active [NUM_BARRIERS];
    logic [NW_BITS-1:0]   ent_size   [NUM_BARRIERS];
    logic [NW_BITS:0]     ent_count  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] ent_mask   [NUM_BARRIERS];

    logic                 req_fire;
    logic [NUM_WARPS-1:0] wid_onehot;
    logic                 sel_active;
    logic [NW_BITS-1:0]   sel_size;
    logic [NW_BITS:0]     sel_count;
    logic [NUM_WARPS-1:0] sel_mask;
    logic [NW_BITS:0]     cnt_next;
    logic                 is_dup;
    logic                 is_last;
    logic                 is_immediate;
    logic                 size_mismatch;
    logic                 new_release;
    logic [NUM_WARPS-1:0] new_release_mask;
    logic                 release_fire;

    assign bar_ready    = !release_valid;
    assign req_fire     = bar_valid && bar_ready;
    assign release_fire = release_valid && release_ready;

    always_comb begin
        wid_onehot       = '0;
        sel_active       = 1'b0;
        sel_size         = '0;
        sel_count        = '0;
        sel_mask         = '0;
        cnt_next         = '0;
        is_dup           = 1'b0;
        is_last          = 1'b0;
        is_immediate     = 1'b0;
        size_mismatch    = 1'b0;
        new_release      = 1'b0;
        new_release_mask = '0;

        wid_onehot    = {{(NUM_WARPS-1){1'b0}}, 1'b1} << bar_wid;
        sel_active    = ent_active[bar_id];
        sel_size      = ent_size[bar_id];
        sel_count     = ent_count[bar_id];
        sel_mask      = ent_mask[bar_id];
        cnt_next      = sel_count + {{NW_BITS{1'b0}}, 1'b1};
        is_dup        = sel_active && ((sel_mask & wid_onehot) != '0);
        // A mismatched size never overrides the size latched by the first arrival.
        is_last       = sel_active && !is_dup && (cnt_next == {1'b0, sel_size});
        is_immediate  = !sel_active && (bar_size_m1 == '0);
        size_mismatch = sel_active && (bar_size_m1 != sel_size);

        new_release      = req_fire && (is_immediate || is_last);
        new_release_mask = is_immediate ? wid_onehot : (sel_mask | wid_onehot);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                ent_active[i] <= 1'b0;
                ent_size[i]   <= '0;
                ent_count[i]  <= '0;
                ent_mask[i]   <= '0;
            end
        end else if (req_fire) begin
            if (!sel_active) begin
                if (bar_size_m1 != '0) begin
                    ent_active[bar_id] <= 1'b1;
                    ent_size[bar_id]   <= bar_size_m1;
                    ent_count[bar_id]  <= '0;
                    ent_mask[bar_id]   <= wid_onehot;
                end
            end else if (!is_dup) begin
                if (is_last) begin
                    ent_active[bar_id] <= 1'b0;
                    ent_size[bar_id]   <= '0;
                    ent_count[bar_id]  <= '0;
                    ent_mask[bar_id]   <= '0;
                end else begin
                    ent_count[bar_id] <= cnt_next;
                    ent_mask[bar_id]  <= sel_mask | wid_onehot;
                end
            end
        end
    end

    // New releases only arrive while the buffer is empty, so load and drain never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            release_valid <= 1'b0;
            release_id    <= '0;
            release_mask  <= '0;
        end else if (new_release) begin
            release_valid <= 1'b1;
            release_id    <= bar_id;
            release_mask  <= new_release_mask;
        end else if (release_fire) begin
            release_valid <= 1'b0;
            release_id    <= '0;
            release_mask  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_dup  <= 1'b0;
            err_size <= 1'b0;
        end else begin
            err_dup  <= req_fire && is_dup;
            err_size <= req_fire && size_mismatch;
        end
    end

    always_comb begin
        stalled_mask = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (ent_active[i]) begin
                stalled_mask = stalled_mask | ent_mask[i];
            end
        end
        if (release_valid) begin
            stalled_mask = stalled_mask | release_mask;
        end
    end

`ifdef BARRIER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_releases     <= '0;
        end else begin
            if (stalled_mask != '0) begin
                perf_stall_cycles <= perf_stall_cycles + {{(PERF_CTR_BITS-1){1'b0}}, 1'b1};
            end
            if (release_fire) begin
                perf_releases <= perf_releases + {{(PERF_CTR_BITS-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit; perf-counter checks build only with BARRIER_PERF_EN.
module tb_warp_barrier_unit;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_BITS      = 2;
    localparam int NB_BITS      = 2;
    localparam int PCB          = 44;

    logic                 clk;
    logic                 reset;
    logic                 bar_valid;
    logic                 bar_ready;
    logic [NW_BITS-1:0]   bar_wid;
    logic [NB_BITS-1:0]   bar_id;
    logic [NW_BITS-1:0]   bar_size_m1;
    logic                 release_valid;
    logic                 release_ready;
    logic [NB_BITS-1:0]   release_id;
    logic [NUM_WARPS-1:0] release_mask;
    logic [NUM_WARPS-1:0] stalled_mask;
    logic                 err_dup;
    logic                 err_size;
`ifdef BARRIER_PERF_EN
    logic [PCB-1:0]       perf_stall_cycles;
    logic [PCB-1:0]       perf_releases;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    warp_barrier_unit #(
        .NUM_WARPS(NUM_WARPS),
        .NUM_BARRIERS(NUM_BARRIERS),
        .NW_BITS(NW_BITS),
        .NB_BITS(NB_BITS),
        .PERF_CTR_BITS(PCB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bar_valid(bar_valid),
        .bar_ready(bar_ready),
        .bar_wid(bar_wid),
        .bar_id(bar_id),
        .bar_size_m1(bar_size_m1),
        .release_valid(release_valid),
        .release_ready(release_ready),
        .release_id(release_id),
        .release_mask(release_mask),
        .stalled_mask(stalled_mask),
        .err_dup(err_dup),
        .err_size(err_size)
`ifdef BARRIER_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_releases(perf_releases)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int wid, input int id, input int size_m1);
        bar_valid   = 1'b1;
        bar_wid     = NW_BITS'(wid);
        bar_id      = NB_BITS'(id);
        bar_size_m1 = NW_BITS'(size_m1);
        tick();
        bar_valid   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bar_valid     = 1'b0;
        bar_wid       = '0;
        bar_id        = '0;
        bar_size_m1   = '0;
        release_ready = 1'b1;
        do_reset();

        chk("rst_rv",      release_valid, 0);
        chk("rst_rmask",   release_mask,  0);
        chk("rst_rid",     release_id,    0);
        chk("rst_stalled", stalled_mask,  0);
        chk("rst_errdup",  err_dup,       0);
        chk("rst_errsize", err_size,      0);
        chk("rst_ready",   bar_ready,     1);

        // four warps meet on barrier 1
        req(0, 1, 3); chk("s1_st0", stalled_mask, 4'b0001); chk("s1_rv0", release_valid, 0);
        req(1, 1, 3); chk("s1_st1", stalled_mask, 4'b0011);
        req(2, 1, 3); chk("s1_st2", stalled_mask, 4'b0111);
        req(3, 1, 3);
        chk("s1_rv",    release_valid, 1);
        chk("s1_rid",   release_id,    1);
        chk("s1_rmask", release_mask,  4'b1111);
        chk("s1_st3",   stalled_mask,  4'b1111);
        chk("s1_ready", bar_ready,     0);
        tick();
        chk("s1_rv_off", release_valid, 0);
        chk("s1_st_clr", stalled_mask,  4'b0000);

        // single-participant barrier releases immediately and stores nothing
        req(2, 0, 0);
        chk("s2_rv",    release_valid, 1);
        chk("s2_rid",   release_id,    0);
        chk("s2_rmask", release_mask,  4'b0100);
        chk("s2_st",    stalled_mask,  4'b0100);
        tick();
        chk("s2_rv_off", release_valid, 0);
        chk("s2_st_clr", stalled_mask,  4'b0000);
        req(3, 0, 0);
        chk("s2b_rmask", release_mask, 4'b1000);
        chk("s2b_rv",    release_valid, 1);
        tick();

        // duplicate arrival is ignored
        req(1, 2, 1); chk("s3_st0", stalled_mask, 4'b0010); chk("s3_dup0", err_dup, 0);
        req(1, 2, 1);
        chk("s3_dup",    err_dup,       1);
        chk("s3_st1",    stalled_mask,  4'b0010);
        chk("s3_rv0",    release_valid, 0);
        tick();
        chk("s3_dup_off", err_dup, 0);
        req(3, 2, 1);
        chk("s3_rv",    release_valid, 1);
        chk("s3_rid",   release_id,    2);
        chk("s3_rmask", release_mask,  4'b1010);
        tick();

        // scheduler back-pressure holds the release, with a request waiting
        release_ready = 1'b0;
        req(0, 1, 1);
        req(2, 1, 1);
        chk("s4_rv", release_valid, 1);
        bar_valid   = 1'b1;
        bar_wid     = 2'd1;
        bar_id      = 2'd3;
        bar_size_m1 = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s4_hold_rv",    release_valid, 1);
            chk("s4_hold_rmask", release_mask,  4'b0101);
            chk("s4_hold_rid",   release_id,    1);
            chk("s4_hold_ready", bar_ready,     0);
        end
        release_ready = 1'b1;
        tick();
        chk("s4_drain_rv",    release_valid, 0);
        chk("s4_drain_ready", bar_ready,     1);
        tick();
        bar_valid = 1'b0;
        chk("s4_acc_rv",    release_valid, 1);
        chk("s4_acc_rid",   release_id,    3);
        chk("s4_acc_rmask", release_mask,  4'b0010);
        tick();
        chk("s4_end_rv", release_valid, 0);

        // size mismatch keeps the latched size
        req(0, 3, 2); chk("s5_err0", err_size, 0);
        req(1, 3, 1);
        chk("s5_err",   err_size,      1);
        chk("s5_st",    stalled_mask,  4'b0011);
        chk("s5_rv0",   release_valid, 0);
        tick();
        chk("s5_err_off", err_size, 0);
        req(2, 3, 2);
        chk("s5_rv",    release_valid, 1);
        chk("s5_rid",   release_id,    3);
        chk("s5_rmask", release_mask,  4'b0111);
        tick();

        // reset with a release pending and the scheduler stalled
        release_ready = 1'b0;
        req(0, 2, 1);
        req(2, 2, 1);
        chk("s6_rv", release_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        release_ready = 1'b1;
        chk("s6_rv_rst",    release_valid, 0);
        chk("s6_rmask_rst", release_mask,  0);
        chk("s6_st_rst",    stalled_mask,  0);
        req(1, 2, 1);
        chk("s6_reuse_st", stalled_mask, 4'b0010);
        chk("s6_reuse_rv", release_valid, 0);

`ifdef BARRIER_PERF_EN
        do_reset();
        chk("p_rst_stall", perf_stall_cycles, 0);
        chk("p_rst_rel",   perf_releases,     0);
        req(0, 1, 3);
        req(1, 1, 3);
        req(2, 1, 3);
        req(3, 1, 3);
        tick();
        chk("p_rel",   perf_releases,     1);
        chk("p_stall", perf_stall_cycles, 4);
        req(0, 1, 3);
        req(1, 1, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("p_mid_st",    stalled_mask,      0);
        chk("p_mid_stall", perf_stall_cycles, 0);
        chk("p_mid_rel",   perf_releases,     0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/warp_barrier_unit.md
Name: warp_barrier_unit

Overview:
- Consumes barrier requests decoded by the GPU unit: valid, barrier id, participant count minus one, plus the issuing warp id.
- Tracks which warps wait on each barrier and signals the warp scheduler to release them once the last participant arrives.
- Sits between the GPU functional unit and the warp scheduler, which uses its masks to hold warps stalled.
- Core-local barriers only.

Parameters:
- NUM_WARPS, 4, warps per core.
- NUM_BARRIERS, 4, barrier table entries.
- NW_BITS, max(1, clog2(NUM_WARPS)), warp id / size width.
- NB_BITS, max(1, clog2(NUM_BARRIERS)), barrier id width.
- PERF_CTR_BITS, 44, width of performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- bar_valid  in  1  barrier request valid.
- bar_ready  out  1  request accepted when bar_valid & bar_ready.
- bar_wid  in  NW_BITS  requesting warp.
- bar_id  in  NB_BITS  barrier id.
- bar_size_m1  in  NW_BITS  participating warps minus one.
- release_valid  out  1  release pending.
- release_ready  in  1  scheduler accepts release.
- release_id  out  NB_BITS  barrier being released.
- release_mask  out  NUM_WARPS  warps to unstall.
- stalled_mask  out  NUM_WARPS  warps currently held by any barrier, including warps in a pending release.
- err_dup  out  1  one-cycle pulse: accepted request from a warp already waiting.
- err_size  out  1  one-cycle pulse: size_m1 mismatches the latched size of an active barrier.

Behaviour:
- Reset values:
  - All table entries inactive: count 0, mask 0, size 0.
  - release_valid, release_mask, release_id, err_dup and err_size are 0; stalled_mask is 0.
  - Reset mid-release drops the pending release, leaving no warps stalled.
- Handshake:
  - bar_ready = !release_valid, forming a single-entry release output buffer.
  - release_valid holds, with stable id and mask, until release_ready is high.
  - It deasserts the cycle after the handshake unless a new release is produced in that same cycle.
- Per entry: active, size_m1 (latched on first arrival), count in NW_BITS+1 bits (arrivals minus one), wait mask in NUM_WARPS bits.
- Accepted request at cycle T, entry e = bar_id:
  - Entry inactive and bar_size_m1 == 0: immediate release. No entry is stored. At T+1, release_valid=1 and release_mask = onehot(bar_wid).
  - Entry inactive and bar_size_m1 > 0: at T+1, active=1, size latched, count=0, mask = onehot(bar_wid).
  - Entry active, wid bit already set in mask: entry unchanged; err_dup pulses at T+1.
  - Entry active, new wid, count+1 < size_m1: count increments and the mask bit is set at T+1.
  - Entry active, new wid, count+1 == size_m1 (last arrival):
    - At T+1, release_valid=1, release_id=e, release_mask = mask | onehot(wid).
    - The entry is cleared at T+1 and is reusable by the next accepted request.
  - Entry active and bar_size_m1 != latched size: err_size pulses at T+1; the latched size is used.
- stalled_mask:
  - OR of all active entry masks, plus release_mask while release_valid is high.
  - A requester's bit appears at T+1.
  - Release bits clear the cycle after the release handshake.
- Latency: request to release_valid is 1 cycle; release handshake to stalled bits cleared is 1 cycle.
- Entries are independent; only one request is processed per cycle, so there are no same-cycle table conflicts.
- The ignored duplicate still consumes the request slot.

Optional Feature:
- Macro: BARRIER_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cycles (PERF_CTR_BITS): increments every cycle stalled_mask != 0.
  - perf_releases (PERF_CTR_BITS): increments on each release handshake.
- Both counters reset to 0 and wrap modulo 2^PERF_CTR_BITS.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Warps 0,1,2,3 request id=1, size_m1=3 on consecutive cycles, release_ready=1 -> stalled_mask goes 0001, 0011, 0111; release_valid pulses one cycle after warp 3's request with release_id=1 and release_mask=1111; stalled_mask is 0000 the cycle after the handshake.
- Warp 2 requests id=0, size_m1=0 -> next cycle release_valid=1, release_mask=0100; no entry is stored.
- Warp 1 requests id=2, size_m1=1 twice -> err_dup pulses once; count unchanged; warp 3 then completes the barrier with release_mask=1010.
- Complete a barrier with release_ready=0 for 5 cycles -> release_valid and release_mask stay stable and bar_ready=0 throughout; a request held on bar_valid is accepted the cycle after release_ready rises.
- Warp 0 requests id=3, size_m1=2; warp 1 requests id=3, size_m1=1 -> err_size pulses; the barrier still waits for a third warp.
- With BARRIER_PERF_EN defined, run the first scenario -> perf_releases=1 and perf_stall_cycles=4 (stalled_mask nonzero for 4 cycles); reset mid-wait -> all masks and counters are 0 the next cycle.
